result_byte_streamer: RTL and testbench



---
 rtl/result_stream_pkg.sv | 12 +
 rtl/result_fifo.sv | 58 +++++
 rtl/result_byte_streamer.sv | 109 ++++++++++
 tb/tb_result_byte_streamer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/result_stream_pkg.sv
// Shared encodings for the result byte streamer: FSM states and output byte width.
package result_stream_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10
    } state_e;

endpackage

// File: rtl/result_fifo.sv
// Small word FIFO; fullness and emptiness come from the occupancy count, so pointers
// are free to wrap and may be equal both when empty and when full.
module result_fifo #(
    parameter int WIDTH     = 15,
    parameter int DEPTH     = 4,
    parameter int ADD_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH:0]       wr_data,
    input  logic                 rd_en,
    output logic [WIDTH:0]       rd_data,
    output logic [ADD_WIDTH:0]   count
);

    localparam logic [ADD_WIDTH-1:0] PTR_ONE = (ADD_WIDTH)'(1);
    localparam logic [ADD_WIDTH:0]   CNT_ONE = (ADD_WIDTH+1)'(1);

    logic [WIDTH:0]       mem_q [DEPTH];
    logic [ADD_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADD_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADD_WIDTH:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only words covered by count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/result_byte_streamer.sv
// Captures CPU writeback words into a FIFO and streams each one out low byte first
// over an 8-bit valid/ready port; dropped words raise a sticky overflow flag.
module result_byte_streamer
    import result_stream_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter int DEPTH     = 4,
    parameter int ADD_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH:0]      in_data,
    input  logic                in_valid,
    output logic [BYTE_W-1:0]   out_byte,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADD_WIDTH:0]  fifo_count,
    output logic                overflow
);

    localparam logic [ADD_WIDTH:0] FULL_CNT = (ADD_WIDTH+1)'(DEPTH);

    state_e              state_q;
    logic [WIDTH:0]      hold_q;
    logic [WIDTH:0]      head;
    logic [BYTE_W-1:0]   out_byte_q;
    logic                out_valid_q;
    logic                overflow_q, overflow_d;
    logic                fifo_full, fifo_empty;
    logic                wr_en, rd_en;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign wr_en      = in_valid && !fifo_full;
    assign rd_en      = !fifo_empty &&
                        ((state_q == ST_IDLE) || ((state_q == ST_HI) && out_ready));
    assign overflow_d = overflow_q | (in_valid & fifo_full);

    result_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADD_WIDTH (ADD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_data (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_en) begin
                        hold_q      <= head;
                        out_byte_q  <= head[BYTE_W-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (out_ready) begin
                        out_byte_q <= hold_q[WIDTH -: BYTE_W];
                        state_q    <= ST_HI;
                    end
                end
                ST_HI: begin
                    // Reloading straight from HI keeps words back to back with no idle bubble.
                    if (out_ready) begin
                        if (rd_en) begin
                            hold_q     <= head;
                            out_byte_q <= head[BYTE_W-1:0];
                            state_q    <= ST_LO;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_byte_streamer.sv
// Randomised and directed bench for result_byte_streamer against a queue-based model.
module tb_result_byte_streamer;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: words waiting in the FIFO, word being emitted, bytes left of it.
    logic [15:0] mq[$];
    logic [15:0] mhold;
    int          mrem;
    logic        movf;
    logic [7:0]  got[$];

    logic        exp_valid;
    logic [7:0]  exp_byte;
    int          exp_count;

    result_byte_streamer #(.WIDTH(15), .DEPTH(4), .ADD_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mhold = '0;
        mrem  = 0;
        movf  = 1'b0;
        got.delete();
        exp_valid = 1'b0;
        exp_byte  = 8'h00;
        exp_count = 0;
    endtask

    // One clock: drive inputs, log any byte the consumer takes, advance the model.
    task automatic drive(input logic iv, input logic [15:0] d, input logic rdy);
        int  pre;
        bit  do_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        #1;
        if (out_valid === 1'b1 && rdy) got.push_back(out_byte);
        @(posedge clk);
        pre    = mq.size();
        do_pop = (pre > 0) && (mrem == 0 || (mrem == 1 && rdy));
        if (mrem > 0 && rdy) mrem--;
        if (do_pop) begin
            mhold = mq.pop_front();
            mrem  = 2;
        end
        if (iv) begin
            if (pre < 4) mq.push_back(d);
            else movf = 1'b1;
        end
        @(negedge clk);
        exp_valid = (mrem > 0);
        exp_byte  = (mrem == 2) ? mhold[7:0] : mhold[15:8];
        exp_count = mq.size();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_chk++; if (out_byte !== 8'h00) begin n_err++; $display("FAIL reset_byte got=%h exp=00", out_byte); end
        n_chk++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_chk++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_single();
        logic [7:0] e[$];
        e = '{8'hC3, 8'hA5};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 16'hA5C3, 1'b1);
            n_chk++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_valid); end
            if (exp_valid) begin
                n_chk++; if (out_byte !== exp_byte) begin n_err++; $display("FAIL single_byte cyc=%0d got=%h exp=%h", c, out_byte, exp_byte); end
            end
            n_chk++; if (fifo_count !== 3'(exp_count)) begin n_err++; $display("FAIL single_count cyc=%0d got=%0d exp=%0d", c, fifo_count, exp_count); end
        end
        n_chk++; if (got.size() != e.size()) begin n_err++; $display("FAIL single_len got=%0d exp=%0d", got.size(), e.size()); end
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            n_chk++; if (got[i] !== e[i]) begin n_err++; $display("FAIL single_seq idx=%0d got=%h exp=%h", i, got[i], e[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e[$];
        e = '{8'h34, 8'h12};
        apply_reset();
        drive(1'b1, 16'h1234, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            n_chk++; if (out_valid !== 1'b1 || out_byte !== 8'h34) begin n_err++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/34", c, out_valid, out_byte); end
            drive(1'b0, 16'h0000, 1'b0);
        end
        for (int c = 0; c < 4; c++) drive(1'b0, 16'h0000, 1'b1);
        n_chk++; if (got.size() != e.size()) begin n_err++; $display("FAIL stall_len got=%0d exp=%0d", got.size(), e.size()); end
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            n_chk++; if (got[i] !== e[i]) begin n_err++; $display("FAIL stall_seq idx=%0d got=%h exp=%h", i, got[i], e[i]); end
        end
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] e[$];
        e = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
        apply_reset();
        for (int w = 1; w <= 6; w++) begin
            drive(1'b1, 16'(w), 1'b0);
            n_chk++; if (overflow !== movf) begin n_err++; $display("FAIL ovf_flag w=%0d got=%b exp=%b", w, overflow, movf); end
        end
        n_chk++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        n_chk++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, 16'h0000, 1'b1);
            n_chk++; if (fifo_count !== 3'(exp_count)) begin n_err++; $display("FAIL ovf_drain_count cyc=%0d got=%0d exp=%0d", c, fifo_count, exp_count); end
        end
        n_chk++; if (got.size() != e.size()) begin n_err++; $display("FAIL ovf_len got=%0d exp=%0d", got.size(), e.size()); end
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            n_chk++; if (got[i] !== e[i]) begin n_err++; $display("FAIL ovf_seq idx=%0d got=%h exp=%h", i, got[i], e[i]); end
        end
        n_chk++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_streaming();
        logic [15:0] w[3];
        logic [7:0]  e[$];
        int          vcyc;
        w = '{16'h1111, 16'h2222, 16'h3333};
        e = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        vcyc = 0;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            drive((c % 2 == 0) && (c < 6), (c < 6) ? w[c/2] : 16'h0, 1'b1);
            if (out_valid === 1'b1) vcyc++;
            n_chk++; if (fifo_count > 3'd1) begin n_err++; $display("FAIL stream_count cyc=%0d got=%0d exp<=1", c, fifo_count); end
            n_chk++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_valid); end
        end
        n_chk++; if (vcyc != 6) begin n_err++; $display("FAIL stream_bubble valid_cycles=%0d exp=6", vcyc); end
        n_chk++; if (got.size() != e.size()) begin n_err++; $display("FAIL stream_len got=%0d exp=%0d", got.size(), e.size()); end
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            n_chk++; if (got[i] !== e[i]) begin n_err++; $display("FAIL stream_seq idx=%0d got=%h exp=%h", i, got[i], e[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  e[$];
        int          pushed;
        int          cyc;
        logic [15:0] d;
        logic        iv;
        pushed = 0;
        cyc = 0;
        apply_reset();
        while ((pushed < 10 || mq.size() > 0 || mrem > 0) && cyc < 300) begin
            iv = (pushed < 10) && ($urandom_range(0, 1) == 1) && (mq.size() < 4);
            d  = 16'($urandom);
            if (iv) begin
                e.push_back(d[7:0]);
                e.push_back(d[15:8]);
                pushed++;
            end
            drive(iv, d, $urandom_range(0, 2) != 0);
            cyc++;
            n_chk++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
            if (exp_valid) begin
                n_chk++; if (out_byte !== exp_byte) begin n_err++; $display("FAIL wrap_byte cyc=%0d got=%h exp=%h", cyc, out_byte, exp_byte); end
            end
            n_chk++; if (fifo_count !== 3'(exp_count)) begin n_err++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, exp_count); end
        end
        drive(1'b0, 16'h0, 1'b1);
        n_chk++; if (got.size() != e.size()) begin n_err++; $display("FAIL wrap_len got=%0d exp=%0d cyc=%0d", got.size(), e.size(), cyc); end
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            n_chk++; if (got[i] !== e[i]) begin n_err++; $display("FAIL wrap_seq idx=%0d got=%h exp=%h", i, got[i], e[i]); end
        end
        n_chk++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        drive(1'b1, 16'hBEEF, 1'b0);
        drive(1'b1, 16'hCAFE, 1'b0);
        drive(1'b1, 16'hF00D, 1'b0);
        drive(1'b1, 16'h0BAD, 1'b0);
        drive(1'b1, 16'hDEAD, 1'b0);
        drive(1'b1, 16'h1357, 1'b0);
        drive(1'b0, 16'h0000, 1'b1);
        n_chk++; if (out_valid !== 1'b1 || out_byte !== 8'hBE) begin n_err++; $display("FAIL midop_hi got=%b/%h exp=1/be", out_valid, out_byte); end
        n_chk++; if (overflow !== 1'b1) begin n_err++; $display("FAIL midop_pre_ovf got=%b exp=1", overflow); end
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midop_valid got=%b exp=0", out_valid); end
        n_chk++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL midop_count got=%0d exp=0", fifo_count); end
        n_chk++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midop_ovf got=%b exp=0", overflow); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 16'h0000, 1'b1);
            n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midop_stale cyc=%0d got=%b exp=0", c, out_valid); end
        end
        n_chk++; if (got.size() != 0) begin n_err++; $display("FAIL midop_bytes got=%0d exp=0", got.size()); end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_streaming();
        test_wrap();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
